lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_ctrl_load_formatter.sv | 23 ++
 rtl/lsu_ctrl.sv | 118 +++++++++++
 tb/tb_lsu_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store controller: access size codes, FSM states,
// default UART address and small decode helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        UART_WAIT = 2'd2,
        RESP      = 2'd3
    } state_e;

    localparam logic [31:0] UART_BASE_DEFAULT = 32'h8000_0000;

    function automatic logic size_legal(input logic [2:0] sz);
        return sz inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
    endfunction

    function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] a);
        return ((sz[1:0] == 2'b01) && a[0]) || ((sz[1:0] == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_formatter.sv
// Combinational load extension: selects and sign/zero-extends the low bytes
// of a memory word according to the load size code.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = '0;
        case (size_i)
            SZ_B:    data_o = {{24{word_i[7]}}, word_i[7:0]};
            SZ_BU:   data_o = {24'b0, word_i[7:0]};
            SZ_H:    data_o = {{16{word_i[15]}}, word_i[15:0]};
            SZ_HU:   data_o = {16'b0, word_i[15:0]};
            SZ_W:    data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one outstanding request, routed to data memory or the
// UART TX register. Optional misaligned-access trapping with MISALIGN_TRAP_EN.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] UART_BASE   = UART_BASE_DEFAULT,
    parameter logic [3:0]  UART_TX_OFF = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    input  logic [31:0] mem_rdata,
    output logic        uart_wr_en,
    output logic [7:0]  uart_wdata,
    input  logic        uart_busy
);

    state_e      state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d, fmt_data;
    logic [2:0]  size_q;
    logic        is_uart, legal, trap, mem_go;

    // TX and status share one register, so the whole 16-byte region decodes to it.
    logic unused_tx_off;
    assign unused_tx_off = ^UART_TX_OFF;

    assign is_uart = (addr_q[31:4] == UART_BASE[31:4]);
    assign legal   = size_legal(size_q);
`ifdef MISALIGN_TRAP_EN
    assign trap    = legal && misaligned(size_q, addr_q[1:0]);
`else
    assign trap    = 1'b0;
`endif
    assign mem_go  = (state_q == ACCESS) && legal && !trap && !is_uart && !reset;

    load_formatter u_fmt (
        .word_i (mem_rdata),
        .size_i (size_q),
        .data_o (fmt_data)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE:      if (req_valid) state_d = ACCESS;
            ACCESS: begin
                state_d = RESP;
                rdata_d = '0;
                if (legal && !trap && !we_q)
                    rdata_d = is_uart ? {31'b0, uart_busy} : fmt_data;
                if (legal && !trap && we_q && is_uart)
                    state_d = UART_WAIT;
            end
            UART_WAIT: if (!uart_busy) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
            end
        end
    end

    // Every output is gated by reset so an aborted operation never strobes.
    assign req_ready  = (state_q == IDLE) && !reset;
    assign mem_rd_en  = mem_go && !we_q;
    assign mem_wr_en  = mem_go && we_q;
    assign mem_addr   = mem_go ? addr_q  : '0;
    assign mem_wdata  = mem_go ? wdata_q : '0;
    assign mem_size   = mem_go ? {1'b0, size_q[1:0]} : '0;
    assign uart_wr_en = (state_q == UART_WAIT) && !uart_busy && !reset;
    assign uart_wdata = uart_wr_en ? wdata_q[7:0] : '0;
    assign resp_valid = (state_q == RESP) && !reset;
    assign resp_rdata = resp_valid ? rdata_q : '0;

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (reset)                  err_q <= 1'b0;
        else if (state_q == ACCESS) err_q <= trap;
    end
    assign resp_err = resp_valid && err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: cycle-level reference model checked every cycle plus
// hand-computed literal expectations; honours MISALIGN_TRAP_EN when defined.
module tb_lsu_ctrl;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_wr_en, mem_rd_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_size;
    logic        uart_wr_en, uart_busy;
    logic [7:0]  uart_wdata;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(mem_rdata),
        .uart_wr_en(uart_wr_en), .uart_wdata(uart_wdata), .uart_busy(uart_busy)
    );

    // Environment memory driven by the DUT strobes
    logic [7:0] ram [0:255];
    logic [7:0] ra;
    always_comb begin
        ra = mem_addr[7:0];
        mem_rdata = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};
    end
    always @(posedge clk) begin
        if (mem_wr_en) begin
            ram[ra] <= mem_wdata[7:0];
            if (mem_size != 3'd0) ram[ra + 8'd1] <= mem_wdata[15:8];
            if (mem_size == 3'd2) begin
                ram[ra + 8'd2] <= mem_wdata[23:16];
                ram[ra + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: byte memory plus the pending request and its age in cycles
    logic [7:0]  mdl [0:255];
    bit          act = 1'b0;
    int          age, tx_age;
    bit          c_we;
    logic [31:0] c_addr, c_wdata, exp_rd;
    logic [2:0]  c_size;
    bit          exp_err;
    int          n_tx = 0, n_resp = 0;
    logic [7:0]  last_tx = 8'h00;
    logic [31:0] rq [$];
    bit          eq [$];

    function automatic bit m_uart(input logic [31:0] a);
        return a[31:4] == 28'h800_0000;
    endfunction
    function automatic bit m_legal(input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd1) || (s == 3'd2) || (s == 3'd4) || (s == 3'd5);
    endfunction
    function automatic bit m_mis(input logic [2:0] s, input logic [31:0] a);
        return TRAP && ((((s == 3'd1) || (s == 3'd5)) && a[0]) || ((s == 3'd2) && (a[1:0] != 2'b00)));
    endfunction
    function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a);
        logic [7:0]  i;
        logic [31:0] w;
        i = a[7:0];
        w = {mdl[i + 8'd3], mdl[i + 8'd2], mdl[i + 8'd1], mdl[i]};
        case (s)
            3'd0:    return w[7]  ? (32'hFFFF_FF00 | {24'b0, w[7:0]})  : {24'b0, w[7:0]};
            3'd4:    return {24'b0, w[7:0]};
            3'd1:    return w[15] ? (32'hFFFF_0000 | {16'b0, w[15:0]}) : {16'b0, w[15:0]};
            3'd5:    return {16'b0, w[15:0]};
            3'd2:    return w;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        bit e_ready, e_rd, e_wr, e_tx, e_resp, go, ust;
        logic [31:0] e_addr, e_wd;
        logic [2:0]  e_sz;
        logic [7:0]  k;
        e_ready = 0; e_rd = 0; e_wr = 0; e_tx = 0; e_resp = 0;
        e_addr = '0; e_wd = '0; e_sz = '0;
        go  = act && m_legal(c_size) && !m_mis(c_size, c_addr);
        ust = go && c_we && m_uart(c_addr);
        if (!reset) begin
            if (!act) e_ready = 1;
            else begin
                if (age == 1 && go && !m_uart(c_addr)) begin
                    e_rd = !c_we; e_wr = c_we; e_addr = c_addr; e_wd = c_wdata;
                    e_sz = {1'b0, c_size[1:0]};
                end
                if (ust && age >= 2 && tx_age < 0 && !uart_busy) e_tx = 1;
                e_resp = ust ? (tx_age >= 0 && age == tx_age + 1) : (age == 2);
            end
        end
        chk("req_ready",  req_ready,  e_ready);
        chk("mem_rd_en",  mem_rd_en,  e_rd);
        chk("mem_wr_en",  mem_wr_en,  e_wr);
        chk("mem_addr",   mem_addr,   e_addr);
        chk("mem_wdata",  mem_wdata,  e_wd);
        chk("mem_size",   mem_size,   e_sz);
        chk("uart_wr_en", uart_wr_en, e_tx);
        chk("uart_wdata", uart_wdata, e_tx ? c_wdata[7:0] : 8'h00);
        chk("resp_valid", resp_valid, e_resp);
        chk("resp_rdata", resp_rdata, e_resp ? exp_rd : 32'h0);
        chk("resp_err",   resp_err,   e_resp ? exp_err : 1'b0);
        if (resp_valid) begin rq.push_back(resp_rdata); eq.push_back(resp_err); n_resp++; end
        if (uart_wr_en) begin n_tx++; last_tx = uart_wdata; end
        // advance the model to the next cycle
        if (reset) act = 0;
        else if (!act) begin
            if (req_valid) begin
                act = 1; age = 1; tx_age = -1;
                c_we = req_we; c_addr = req_addr; c_wdata = req_wdata; c_size = req_size;
            end
        end else begin
            if (age == 1) begin
                exp_err = m_legal(c_size) && m_mis(c_size, c_addr);
                exp_rd  = 32'h0;
                if (go && !c_we) exp_rd = m_uart(c_addr) ? {31'b0, uart_busy} : m_load(c_size, c_addr);
                if (go && c_we && !m_uart(c_addr)) begin
                    k = c_addr[7:0];
                    mdl[k] = c_wdata[7:0];
                    if (c_size[1:0] != 2'd0) mdl[k + 8'd1] = c_wdata[15:8];
                    if (c_size[1:0] == 2'd2) begin
                        mdl[k + 8'd2] = c_wdata[23:16];
                        mdl[k + 8'd3] = c_wdata[31:24];
                    end
                end
            end
            if (e_resp) act = 0;
            else begin
                if (e_tx) tx_age = age;
                age++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz);
        int n = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_size = sz;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 20) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    function automatic logic [31:0] rsp(input int i);
        return (rq.size() > i) ? rq[i] : 32'hBAD0_BAD0;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; mdl[i] = 8'h00; end
        reset = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        req_size = '0; uart_busy = 0;
        idle(3);
        reset = 0;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1'b1);
        @(posedge clk); #1;

        issue(1, 32'h10, 32'hDEAD_BEEF, 3'b010);   // 0
        issue(0, 32'h10, 32'h0, 3'b010);           // 1
        issue(1, 32'h20, 32'h0000_80F0, 3'b010);   // 2
        issue(0, 32'h20, 32'h0, 3'b000);           // 3 LB
        issue(0, 32'h20, 32'h0, 3'b100);           // 4 LBU
        issue(0, 32'h20, 32'h0, 3'b001);           // 5 LH
        issue(0, 32'h20, 32'h0, 3'b101);           // 6 LHU
        idle(3);

        uart_busy = 1;                             // 7 UART store, busy ~5 cycles
        issue(1, 32'h8000_0000, 32'h0000_0041, 3'b000);
        idle(4);
        uart_busy = 0;
        idle(3);

        uart_busy = 1;                             // 8 UART status load
        issue(0, 32'h8000_0000, 32'h0, 3'b010);
        idle(2);
        uart_busy = 0;

        issue(0, 32'h13, 32'h0, 3'b010);           // 9 misaligned LW
        issue(1, 32'h22, 32'h0000_A5C3, 3'b001);   // 10 SH
        issue(0, 32'h20, 32'h0, 3'b010);           // 11
        issue(0, 32'h23, 32'h0, 3'b100);           // 12
        issue(0, 32'h20, 32'h0, 3'b011);           // 13 illegal size
        issue(0, 32'h21, 32'h0, 3'b001);           // 14 misaligned LH
        idle(4);

        uart_busy = 1;                             // aborted UART store
        issue(1, 32'h8000_0004, 32'h0000_0055, 3'b000);
        idle(2);
        reset = 1; uart_busy = 0;
        idle(1);
        reset = 0;
        @(negedge clk);
        chk("ready_after_abort", req_ready, 1'b1);
        @(posedge clk); #1;
        idle(4);

        chk("resp_count",  n_resp, 15);
        chk("lw_10",       rsp(1),  32'hDEAD_BEEF);
        chk("lb_20",       rsp(3),  32'hFFFF_FFF0);
        chk("lbu_20",      rsp(4),  32'h0000_00F0);
        chk("lh_20",       rsp(5),  32'hFFFF_80F0);
        chk("lhu_20",      rsp(6),  32'h0000_80F0);
        chk("uart_status", rsp(8),  32'h0000_0001);
        chk("lw_13",       rsp(9),  TRAP ? 32'h0 : 32'h0000_00DE);
        chk("lw_13_err",   (eq.size() > 9) ? eq[9] : 1'bx, TRAP);
        chk("lw_20_after_sh", rsp(11), 32'hA5C3_80F0);
        chk("lbu_23",      rsp(12), 32'h0000_00A5);
        chk("bad_size",    rsp(13), 32'h0);
        chk("lh_21",       rsp(14), TRAP ? 32'h0 : 32'hFFFF_C380);
        chk("uart_pulses", n_tx, 1);
        chk("uart_byte",   last_tx, 8'h41);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
